pwm_multi_gen: RTL and testbench

Multi-channel PWM generator for the VFD driver path. It replaces the single undriven `pwm` output at top level with `CH_NUM` phase-aligned outputs. All channels share one period counter, which advances on the 1 µs `pluse_us` tick from `clk_rst_top`. Period and duty settings come from `hmi_top`, are double-buffered, and only take effect at a period boundary.

---
 rtl/pwm_multi_gen_if.sv | 26 ++
 rtl/pwm_multi_gen.sv | 228 ++++++++++++++++++++++
 tb/tb_pwm_multi_gen.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_gen_if.sv
// Control/status bundle for pwm_multi_gen: time-base tick, run/config inputs
// from the HMI side and the PWM outputs back to the driver path.
interface pwm_multi_gen_if #(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 8
);
  logic                    pluse_us;
  logic                    en;
  logic                    mode;
  logic [CNT_W-1:0]        period;
  logic [CH_NUM*CNT_W-1:0] duty;
  logic                    load;
  logic [CH_NUM-1:0]       pwm;
  logic                    period_end;
  logic                    ramp_done;

  modport master (
    output pluse_us, en, mode, period, duty, load,
    input  pwm, period_end, ramp_done
  );

  modport slave (
    input  pluse_us, en, mode, period, duty, load,
    output pwm, period_end, ramp_done
  );
endinterface

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: CH_NUM phase-aligned outputs on one shared counter,
// double-buffered settings applied at period boundaries. Soft start: PWM_SOFTSTART_EN.
module pwm_multi_gen #(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 8
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  pwm_multi_gen_if.slave  bus
);

  localparam logic [CNT_W-1:0]        CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]        CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CH_NUM*CNT_W-1:0] DUTY_ZERO = {(CH_NUM*CNT_W){1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    dir_q, dir_d;
  logic                    stg_mode_q, stg_mode_d;
  logic [CNT_W-1:0]        stg_period_q, stg_period_d;
  logic [CH_NUM*CNT_W-1:0] stg_duty_q, stg_duty_d;
  logic                    sh_mode_q, sh_mode_d;
  logic [CNT_W-1:0]        sh_period_q, sh_period_d;
  logic [CH_NUM*CNT_W-1:0] sh_duty_q, sh_duty_d;
  logic                    pend_q, pend_d;
  logic [CH_NUM-1:0]       pwm_q, pwm_d;
  logic                    period_end_q, period_end_d;
  logic                    ramp_done_q, ramp_done_d;

  logic                    run_s;
  logic                    abort_s;
  logic                    boundary_s;
  logic                    apply_s;
  logic [CNT_W-1:0]        last_s;
  logic [CH_NUM*CNT_W-1:0] eff_s;

  assign run_s   = (state_q == ST_RUN);
  assign last_s  = sh_period_q - CNT_ONE;
  assign abort_s = run_s && !bus.en;
  // A zero period never produces a boundary, so the counter stays parked at 0.
  assign boundary_s = run_s && bus.en && bus.pluse_us && (sh_period_q != CNT_ZERO) &&
                      (sh_mode_q ? (dir_q && (cnt_q == CNT_ZERO)) : (cnt_q == last_s));
  // Shadow is written directly in IDLE, or when an abort/boundary meets fresh values.
  assign apply_s = (!run_s && bus.load) || ((abort_s || boundary_s) && (pend_q || bus.load));

  // Staging capture, shadow transfer and pending flag.
  always_comb begin
    stg_mode_d   = stg_mode_q;
    stg_period_d = stg_period_q;
    stg_duty_d   = stg_duty_q;
    sh_mode_d    = sh_mode_q;
    sh_period_d  = sh_period_q;
    sh_duty_d    = sh_duty_q;
    pend_d       = 1'b0;
    if (bus.load) begin
      stg_mode_d   = bus.mode;
      stg_period_d = bus.period;
      stg_duty_d   = bus.duty;
    end else begin
      stg_mode_d   = stg_mode_q;
      stg_period_d = stg_period_q;
      stg_duty_d   = stg_duty_q;
    end
    if (apply_s) begin
      sh_mode_d   = stg_mode_d;
      sh_period_d = stg_period_d;
      sh_duty_d   = stg_duty_d;
    end else begin
      sh_mode_d   = sh_mode_q;
      sh_period_d = sh_period_q;
      sh_duty_d   = sh_duty_q;
    end
    if (run_s && !abort_s && !boundary_s) begin
      pend_d = pend_q | bus.load;
    end else begin
      pend_d = 1'b0;
    end
  end

  // Run/idle FSM, shared counter and output compare.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    pwm_d        = pwm_q;
    period_end_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        dir_d = 1'b0;
        pwm_d = {CH_NUM{1'b0}};
        if (bus.en) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!bus.en) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
          dir_d   = 1'b0;
          pwm_d   = {CH_NUM{1'b0}};
        end else if (bus.pluse_us) begin
          if (sh_period_q == CNT_ZERO) begin
            cnt_d = CNT_ZERO;
            dir_d = 1'b0;
            pwm_d = {CH_NUM{1'b0}};
          end else begin
            for (int k = 0; k < CH_NUM; k++) begin
              pwm_d[k] = (cnt_q < eff_s[k*CNT_W +: CNT_W]);
            end
            if (boundary_s) begin
              cnt_d        = CNT_ZERO;
              dir_d        = 1'b0;
              period_end_d = 1'b1;
            end else if (!sh_mode_q) begin
              cnt_d = cnt_q + CNT_ONE;
            end else if (!dir_q) begin
              // Top of the triangle: stay on P-1 for a second tick, then descend.
              if (cnt_q == last_s) begin
                dir_d = 1'b1;
              end else begin
                cnt_d = cnt_q + CNT_ONE;
              end
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        dir_d   = 1'b0;
        pwm_d   = {CH_NUM{1'b0}};
      end
    endcase
  end

`ifdef PWM_SOFTSTART_EN
  logic [CH_NUM*CNT_W-1:0] eff_q, eff_d;

  assign eff_s = eff_q;

  // Effective duties ramp one step per period toward the shadow duties.
  always_comb begin
    eff_d = eff_q;
    if (!run_s) begin
      eff_d = DUTY_ZERO;
    end else if (period_end_d) begin
      for (int k = 0; k < CH_NUM; k++) begin
        if (eff_q[k*CNT_W +: CNT_W] < sh_duty_d[k*CNT_W +: CNT_W]) begin
          eff_d[k*CNT_W +: CNT_W] = eff_q[k*CNT_W +: CNT_W] + CNT_ONE;
        end else if (eff_q[k*CNT_W +: CNT_W] > sh_duty_d[k*CNT_W +: CNT_W]) begin
          eff_d[k*CNT_W +: CNT_W] = eff_q[k*CNT_W +: CNT_W] - CNT_ONE;
        end else begin
          eff_d[k*CNT_W +: CNT_W] = eff_q[k*CNT_W +: CNT_W];
        end
      end
    end else begin
      eff_d = eff_q;
    end
    ramp_done_d = (eff_d == sh_duty_d);
  end

  // Effective duty register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      eff_q <= DUTY_ZERO;
    end else begin
      eff_q <= eff_d;
    end
  end
`else
  assign eff_s = sh_duty_q;

  // Without soft start the outputs track shadow duties immediately.
  always_comb begin
    ramp_done_d = 1'b1;
  end
`endif

  // State, counter, register sets and registered outputs.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      dir_q        <= 1'b0;
      stg_mode_q   <= 1'b0;
      stg_period_q <= CNT_ZERO;
      stg_duty_q   <= DUTY_ZERO;
      sh_mode_q    <= 1'b0;
      sh_period_q  <= CNT_ZERO;
      sh_duty_q    <= DUTY_ZERO;
      pend_q       <= 1'b0;
      pwm_q        <= {CH_NUM{1'b0}};
      period_end_q <= 1'b0;
      ramp_done_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      stg_mode_q   <= stg_mode_d;
      stg_period_q <= stg_period_d;
      stg_duty_q   <= stg_duty_d;
      sh_mode_q    <= sh_mode_d;
      sh_period_q  <= sh_period_d;
      sh_duty_q    <= sh_duty_d;
      pend_q       <= pend_d;
      pwm_q        <= pwm_d;
      period_end_q <= period_end_d;
      ramp_done_q  <= ramp_done_d;
    end
  end

  assign bus.pwm        = pwm_q;
  assign bus.period_end = period_end_q;
  assign bus.ramp_done  = ramp_done_q;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Scoreboard bench for pwm_multi_gen (default build): directed vectors push
// expected {ramp_done, period_end, pwm} tagged with a cycle; a monitor compares.
module tb_pwm_multi_gen;

  logic clk_sys  = 1'b0;
  logic clk_run  = 1'b1;
  logic rst_n    = 1'b0;
  int   cyc_cnt  = 0;
  int   n_vec    = 0;
  int   n_miss   = 0;

  typedef struct {
    int         cyc;
    logic [5:0] exp;
    string      name;
  } sb_entry_t;

  sb_entry_t  sb_q[$];
  sb_entry_t  mon_e;
  logic [5:0] mon_act;
  event       chk_ev;

  pwm_multi_gen_if #(.CH_NUM(4), .CNT_W(8)) bus ();

  pwm_multi_gen #(.CH_NUM(4), .CNT_W(8)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always begin
    #5;
    if (clk_run) clk_sys = ~clk_sys;
  end

  always @(posedge clk_sys) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compare every expectation whose target cycle has arrived.
  always @(negedge clk_sys or chk_ev) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
      mon_e   = sb_q.pop_front();
      mon_act = {bus.ramp_done, bus.period_end, bus.pwm};
      n_vec++;
      if (mon_e.cyc != cyc_cnt || mon_act !== mon_e.exp) begin
        n_miss++;
        $display("FAIL %s: got rd/pe/pwm=%b, expected %b (cycle %0d, due %0d)",
                 mon_e.name, mon_act, mon_e.exp, cyc_cnt, mon_e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb_q.size());
    $fatal(1);
  end

  task automatic set_cfg(input logic md, input logic [7:0] per, input logic [31:0] dty);
    bus.mode   = md;
    bus.period = per;
    bus.duty   = dty;
  endtask

  task automatic step(input logic tk, input logic ld, input logic chk,
                      input logic [3:0] ep, input logic epe, input string nm);
    bus.pluse_us = tk;
    bus.load     = ld;
    if (chk) sb_q.push_back('{cyc_cnt + 1, {1'b1, epe, ep}, nm});
    @(posedge clk_sys);
    #1;
    bus.pluse_us = 1'b0;
    bus.load     = 1'b0;
  endtask

  initial begin
    int c;
    logic [3:0] ep;
    bus.pluse_us = 1'b0;
    bus.en       = 1'b0;
    bus.load     = 1'b0;
    set_cfg(1'b0, 8'd0, 32'd0);

    step(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, "reset_state");
    rst_n = 1'b1;

    // Edge mode, P=10, duties ch0..ch3 = 0,3,10,12
    set_cfg(1'b0, 8'd10, {8'd12, 8'd10, 8'd3, 8'd0});
    step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, "");
    bus.en = 1'b1;
    step(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, "idle_to_run");
    for (int i = 0; i < 25; i++) begin
      c = i % 10;
      step(1'b1, 1'b0, 1'b1, {1'b1, 1'b1, (c < 3), 1'b0}, (c == 9), "edge_basic");
    end
    step(1'b0, 1'b0, 1'b1, 4'b1100, 1'b0, "hold_no_tick");

    // Deferred load: P=5 requested at count 4 of a P=10 period
    for (int i = 0; i < 9; i++) begin
      c = (5 + i) % 10;
      step(1'b1, 1'b0, 1'b1, {1'b1, 1'b1, (c < 3), 1'b0}, (c == 9), "edge_to_cnt4");
    end
    set_cfg(1'b0, 8'd5, {8'd12, 8'd10, 8'd3, 8'd0});
    step(1'b1, 1'b1, 1'b1, 4'b1100, 1'b0, "defer_load");
    for (int i = 5; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b1, 4'b1100, (i == 9), "defer_old_period");
    end
    for (int i = 0; i < 14; i++) begin
      c = i % 5;
      step(1'b1, 1'b0, 1'b1, {1'b1, 1'b1, (c < 3), 1'b0}, (c == 4), "defer_new_p5");
    end

    // Load coincident with the boundary tick: P=7, duties ch0..ch3 = 5,1,7,0
    set_cfg(1'b0, 8'd7, {8'd0, 8'd7, 8'd1, 8'd5});
    step(1'b1, 1'b1, 1'b1, 4'b1100, 1'b1, "boundary_load");
    for (int i = 0; i < 7; i++) begin
      ep = {1'b0, 1'b1, (i < 1), (i < 5)};
      step(1'b1, 1'b0, 1'b1, ep, (i == 6), "boundary_new_p7");
      step(1'b0, 1'b0, 1'b1, ep, 1'b0, "p7_between_ticks");
    end

    // Abort mid-period with center-mode values pending
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, {1'b0, 1'b1, (i < 1), (i < 5)}, 1'b0, "p7_pre_abort");
    end
    set_cfg(1'b1, 8'd8, {4{8'd2}});
    step(1'b1, 1'b1, 1'b1, 4'b0101, 1'b0, "abort_pend_load");
    bus.en = 1'b0;
    step(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, "abort_pwm_zero");
    step(1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, "idle_tick");
    bus.en = 1'b1;
    step(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, "reenable");

    // Center mode P=8 duty 2: 16-tick period, high on count 0 and 1 both ways
    for (int i = 0; i < 32; i++) begin
      c = (i % 16 < 8) ? (i % 16) : (15 - i % 16);
      step(1'b1, 1'b0, 1'b1, (c < 2) ? 4'b1111 : 4'b0000, (i % 16 == 15), "center");
    end

    // Zero period: stays RUN with outputs low and no period_end
    bus.en = 1'b0;
    set_cfg(1'b0, 8'd0, {4{8'd5}});
    step(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, "p0_load");
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, "p0_hold");
    end

    // Duty above period: constant high, period_end every 4 ticks
    bus.en = 1'b0;
    set_cfg(1'b0, 8'd4, {4{8'd5}});
    step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, "");
    bus.en = 1'b1;
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "");
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 4'b1111, (i == 3), "duty_over_period");
    end

    // Asynchronous reset with the clock stopped
    @(negedge clk_sys);
    clk_run = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    sb_q.push_back('{cyc_cnt, 6'b100000, "async_reset"});
    ->chk_ev;
    #1;
    bus.en  = 1'b0;
    rst_n   = 1'b1;
    clk_run = 1'b1;
    step(1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, "post_reset_idle");

    repeat (3) @(posedge clk_sys);
    #1;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d unchecked expectations, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
